// File: rtl/mult_seq_ctrl.sv
// Sequential 2N x 2N multiplier: four N+1-bit signed partial products are issued to an
// external fixed-latency DSP slice, then shifted and summed as they return.

module mult_seq_slice #(
  parameter int N = 8
) (
  input  logic [2*N-1:0] op,
  input  logic           sel_hi,
  input  logic           sign,
  input  logic           en,
  output logic [N:0]     ext
);

  // Low halves are always magnitudes; only the high half carries the sign.
  always_comb begin
    ext = '0;
    if (en) begin
      if (sel_hi) ext = {sign & op[2*N-1], op[2*N-1:N]};
      else        ext = {1'b0, op[N-1:0]};
    end
  end

endmodule

module mult_seq_ctrl #(
  parameter int N   = 8,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sign,
  input  logic [2*N-1:0] in_a,
  input  logic [2*N-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*N-1:0] out_p,
  output logic           dsp_valid,
  output logic [N:0]     dsp_a,
  output logic [N:0]     dsp_b,
  input  logic [2*N+1:0] dsp_p
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic           sign;
    logic [2*N-1:0] a;
    logic [2*N-1:0] b;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;
  logic [1:0]     k;
  logic [4*N-1:0] acc;
  logic [4*N-1:0] pp_ext;
  logic [4*N-1:0] pp_sh;
  logic [4*N-1:0] acc_nxt;
  logic           accept;
  logic           emerge;
  logic [1:0]     emerge_k;
  logic           last_in;

  // Tag pipeline: index 0 is the live issue, index LAT lines up with dsp_p.
  logic [LAT:1]      vld_q;
  logic [LAT:1][1:0] k_q;
  logic [LAT:0]      vld_pipe;
  logic [LAT:0][1:0] k_pipe;

  assign vld_pipe = {vld_q, dsp_valid};
  assign k_pipe   = {k_q, k};
  assign emerge   = vld_pipe[LAT];
  assign emerge_k = k_pipe[LAT];
  assign last_in  = emerge && (emerge_k == 2'd3);

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign dsp_valid = (state == ISSUE);
  assign out_valid = (state == DONE);

  // Operand slice selection: k[1] picks the A half, k[0] picks the B half.
  logic [1:0][2*N-1:0] ops;
  logic [1:0]          sel;
  logic [1:0][N:0]     ext;

  assign ops[0] = req_q.a;
  assign ops[1] = req_q.b;
  assign sel[0] = k[1];
  assign sel[1] = k[0];

  for (genvar g = 0; g < 2; g++) begin : g_slice
    mult_seq_slice #(.N(N)) u_slice (
      .op     (ops[g]),
      .sel_hi (sel[g]),
      .sign   (req_q.sign),
      .en     (dsp_valid),
      .ext    (ext[g])
    );
  end

  assign dsp_a = ext[0];
  assign dsp_b = ext[1];

  assign pp_ext = {{(2*N-2){dsp_p[2*N+1]}}, dsp_p};

  always_comb begin
    pp_sh = pp_ext;
    case (emerge_k)
      2'd0:       pp_sh = pp_ext;
      2'd1, 2'd2: pp_sh = pp_ext << N;
      default:    pp_sh = pp_ext << (2*N);
    endcase
    acc_nxt = acc + pp_sh;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = ISSUE;
      ISSUE:   if (k == 2'd3) state_nxt = DRAIN;
      DRAIN:   if (last_in)   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      vld_q <= '0;
      k_q   <= '0;
      acc   <= '0;
      out_p <= '0;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      k     <= (state == ISSUE) ? k + 2'd1 : 2'd0;
      vld_q <= vld_pipe[LAT-1:0];
      k_q   <= k_pipe[LAT-1:0];
      if (accept) begin
        req_q <= '{sign: in_sign, a: in_a, b: in_b};
        acc   <= '0;
      end else if (emerge) begin
        acc <= acc_nxt;
      end
      if ((state == DRAIN) && last_in) out_p <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl (N=8, LAT=2) with a behavioural DSP slice and an
// arithmetic product model.

module tb_mult_seq_ctrl;

  localparam int N   = 8;
  localparam int LAT = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [2*N-1:0]   in_a;
  logic [2*N-1:0]   in_b;
  logic             out_valid;
  logic             out_ready;
  logic [4*N-1:0]   out_p;
  logic             dsp_valid;
  logic [N:0]       dsp_a;
  logic [N:0]       dsp_b;
  logic [2*N+1:0]   dsp_p;

  int nvec = 0;
  int nerr = 0;

  mult_seq_ctrl #(.N(N), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .dsp_valid (dsp_valid),
    .dsp_a     (dsp_a),
    .dsp_b     (dsp_b),
    .dsp_p     (dsp_p)
  );

  always #5 clk = ~clk;

  // DSP slice: signed product delivered LAT(=2) cycles after the issue; garbage otherwise.
  logic [2*N+1:0] d1, d2;
  always @(posedge clk) begin
    int prod;
    prod = int'($signed(dsp_a)) * int'($signed(dsp_b));
    d1 <= dsp_valid ? (2*N+2)'(prod) : (2*N+2)'($urandom);
    d2 <= d1;
  end
  assign dsp_p = d2;

  function automatic logic [31:0] ref_mul(input logic s, input logic [15:0] a, input logic [15:0] b);
    longint x, y;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    return 32'(x * y);
  endfunction

  // Drive one request and follow it to its first out_valid cycle.
  task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic rdy, input logic noise,
                        output logic [31:0] p, output int lat, output int pulses);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1; in_sign = s; in_a = a; in_b = b; out_ready = rdy;
    lat = 0; pulses = 0;
    do begin
      @(negedge clk);
      lat++;
      if (dsp_valid) pulses++;
      if (noise) begin
        in_a = 16'($urandom); in_b = 16'($urandom); in_sign = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end while (!out_valid && lat < 60);
    in_valid = 1'b0;
    p = out_p;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    nvec++; if (dsp_valid !== 1'b0) begin nerr++; $display("FAIL reset_dsp_valid: got %b expected 0", dsp_valid); end
    nvec++; if (out_p !== 32'h0) begin nerr++; $display("FAIL reset_out_p: got %h expected 0", out_p); end
    rst = 1'b0;
    @(negedge clk);
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_unsigned_max;
    logic [31:0] p; int lat, pulses;
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, p, lat, pulses);
    nvec++; if (p !== 32'hFFFE0001) begin nerr++; $display("FAIL umax_product: got %h expected fffe0001", p); end
    nvec++; if (lat !== 5 + LAT) begin nerr++; $display("FAIL umax_latency: got %0d expected %0d", lat, 5 + LAT); end
    nvec++; if (pulses !== 4) begin nerr++; $display("FAIL umax_pulses: got %0d expected 4", pulses); end
    @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL umax_one_cycle: got %b expected 0", out_valid); end
  endtask

  task automatic test_signed;
    logic [31:0] p; int lat, pulses;
    run_op(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b0, p, lat, pulses);
    nvec++; if (p !== 32'h40000000) begin nerr++; $display("FAIL smin_sq: got %h expected 40000000", p); end
    run_op(1'b1, 16'hFFFF, 16'h0002, 1'b1, 1'b0, p, lat, pulses);
    nvec++; if (p !== 32'hFFFFFFFE) begin nerr++; $display("FAIL sneg1_x2: got %h expected fffffffe", p); end
    nvec++; if (lat !== 5 + LAT) begin nerr++; $display("FAIL signed_latency: got %0d expected %0d", lat, 5 + LAT); end
  endtask

  task automatic test_stall;
    logic [31:0] p, e; int lat, pulses; logic [15:0] a, b; logic s;
    a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
    e = ref_mul(s, a, b);
    run_op(s, a, b, 1'b0, 1'b0, p, lat, pulses);
    nvec++; if (p !== e) begin nerr++; $display("FAIL stall_product: got %h expected %h", p, e); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b1 || out_p !== e || in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL stall_hold[%0d]: got valid=%b p=%h ready=%b expected valid=1 p=%h ready=0",
                 i, out_valid, out_p, in_ready, e);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL stall_release: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignore_busy;
    logic [31:0] p, e; int lat, pulses; logic [15:0] a, b;
    a = 16'($urandom); b = 16'($urandom);
    e = ref_mul(1'b1, a, b);
    run_op(1'b1, a, b, 1'b1, 1'b1, p, lat, pulses);
    nvec++; if (p !== e) begin nerr++; $display("FAIL busy_product: got %h expected %h", p, e); end
    nvec++; if (pulses !== 4) begin nerr++; $display("FAIL busy_pulses: got %0d expected 4", pulses); end
    nvec++; if (lat !== 5 + LAT) begin nerr++; $display("FAIL busy_latency: got %0d expected %0d", lat, 5 + LAT); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] p; int lat, pulses, seen;
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'($urandom); in_a = 16'($urandom) | 16'h0101; in_b = 16'($urandom) | 16'h0101;
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    nvec++;
    if (out_p !== 32'h0 || out_valid !== 1'b0 || dsp_valid !== 1'b0 || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL abort_reset_state: got p=%h valid=%b dsp=%b ready=%b expected 0/0/0/0",
               out_p, out_valid, dsp_valid, in_ready);
    end
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    nvec++; if (seen !== 0) begin nerr++; $display("FAIL abort_no_output: got %0d out_valid cycles expected 0", seen); end
    run_op(1'b0, 16'h1234, 16'h5678, 1'b1, 1'b0, p, lat, pulses);
    nvec++; if (p !== 32'h06260060) begin nerr++; $display("FAIL abort_next_product: got %h expected 06260060", p); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] p, e; int lat, pulses, stall; logic [15:0] a, b; logic s;
    for (int n = 0; n < 1000; n++) begin
      s = 1'($urandom);
      case ($urandom_range(0, 7))
        0: a = 16'h8000;
        1: a = 16'hFFFF;
        2: a = 16'h0000;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: b = 16'h8000;
        1: b = 16'hFFFF;
        2: b = 16'h7FFF;
        default: b = 16'($urandom);
      endcase
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      e = ref_mul(s, a, b);
      run_op(s, a, b, (stall == 0), 1'b0, p, lat, pulses);
      nvec++;
      if (p !== e || lat !== 5 + LAT) begin
        nerr++;
        $display("FAIL b2b[%0d]: got p=%h lat=%0d expected p=%h lat=%0d (s=%b a=%h b=%h)",
                 n, p, lat, e, 5 + LAT, s, a, b);
      end
      if (stall != 0) begin
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset;
    test_unsigned_max;
    test_signed;
    test_stall;
    test_ignore_busy;
    test_reset_abort;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
